// File: rtl/pcs_pkg.sv
// pcs_pkg: shared PCS TX constants and scheduler state type
package pcs_pkg;
  localparam int DATA_W = 64;
  localparam int HEAD_W = 2;
  localparam int SEQ_MAX = DATA_W / HEAD_W;
  localparam int SEQ_W = $clog2(SEQ_MAX + 1);
  localparam int AM_INTERVAL_40G = 16383;
  typedef enum logic {IDLE, RUN} sched_state_e;
endpackage

// File: rtl/pcs_tx_sched_if.sv
// pcs_tx_sched_if: scheduler enable in, slot timing and debug counters out
interface pcs_tx_sched_if #(
  parameter int SEQ_W = 6,
  parameter int AM_CNT_W = 14
);
  logic en_i;
  logic [SEQ_W-1:0] seq_o;
  logic gb_full_o;
  logic am_v_o;
  logic scram_v_o;
  logic ready_o;
  logic [AM_CNT_W-1:0] blk_cnt_o;
  modport master (
    input en_i,
    output seq_o, gb_full_o, am_v_o, scram_v_o, ready_o, blk_cnt_o
  );
  modport slave (
    output en_i,
    input seq_o, gb_full_o, am_v_o, scram_v_o, ready_o, blk_cnt_o
  );
endinterface

// File: rtl/gb_seq_cnt.sv
// gb_seq_cnt: gearbox sequence counter wrapping 0..SEQ_MAX with full flag
module gb_seq_cnt #(
  parameter int SEQ_W = 6,
  parameter int SEQ_MAX = 32
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en,
  input  logic             clr,
  output logic [SEQ_W-1:0] seq,
  output logic             full
);
  assign full = seq == SEQ_W'(SEQ_MAX);
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) seq <= '0;
    else if (clr) seq <= '0;
    else if (en) seq <= full ? '0 : seq + 1'b1;
  end
endmodule

// File: rtl/pcs_tx_sched.sv
// pcs_tx_sched: PCS TX slot scheduler driving MAC ready, scrambler advance and AM insertion
module pcs_tx_sched #(
  parameter bit IS_10G = 1'b0,
  parameter int DATA_W = 64,
  parameter int HEAD_W = 2,
  parameter int SEQ_W = $clog2(DATA_W / HEAD_W + 1),
  parameter int SEQ_MAX = DATA_W / HEAD_W,
  parameter int AM_INTERVAL = pcs_pkg::AM_INTERVAL_40G,
  parameter int AM_CNT_W = $clog2(AM_INTERVAL)
) (
  input logic clk,
  input logic nreset,
  pcs_tx_sched_if.master sch
);
  import pcs_pkg::*;
  sched_state_e state_q;
  logic in_run, go, full, am_pend, data_slot;
  logic [SEQ_W-1:0] seq;
  logic [AM_CNT_W-1:0] blk_q;
  assign in_run = state_q == RUN;
  assign go = in_run & sch.en_i;
  gb_seq_cnt #(.SEQ_W(SEQ_W), .SEQ_MAX(SEQ_MAX)) u_seq (
    .clk(clk),
    .nreset(nreset),
    .en(in_run),
    .clr(!go),
    .seq(seq),
    .full(full)
  );
  assign data_slot = in_run & ~full & ~am_pend;
  assign sch.seq_o = seq;
  assign sch.gb_full_o = in_run & full;
  assign sch.am_v_o = !IS_10G & in_run & ~full & am_pend;
  assign sch.scram_v_o = data_slot;
  assign sch.ready_o = data_slot;
  assign sch.blk_cnt_o = blk_q;
  // a pending marker survives full cycles and lands in the next non-full slot
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      am_pend <= 1'b0;
      blk_q <= '0;
    end else begin
      state_q <= sch.en_i ? RUN : IDLE;
      if (!go) begin
        am_pend <= !IS_10G && !in_run && sch.en_i;
        blk_q <= '0;
      end else if (!full) begin
        if (am_pend) am_pend <= 1'b0;
        else if (blk_q == AM_CNT_W'(AM_INTERVAL - 1)) begin
          blk_q <= '0;
          am_pend <= !IS_10G;
        end else blk_q <= blk_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pcs_tx_sched.sv
// tb_pcs_tx_sched: scoreboard bench for four scheduler configurations
module tb_pcs_tx_sched;
  typedef struct packed {
    logic [5:0] seq;
    logic full;
    logic am;
    logic scr;
    logic rdy;
    logic [15:0] blk;
  } exp_t;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic [3:0] en = '0;
  bit mon_en = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q[4][$];
  bit run_m[4];
  int k_m[4];
  int j_m[4];
  int ival[4] = '{16383, 4, 31, 16383};
  bit ten[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  int gaps[$];
  int rcnt = 0;
  bit seen = 1'b0;
  int hit31 = 0;
  logic prev_full2 = 1'b0;
  logic [5:0] o_seq[4];
  logic o_full[4], o_am[4], o_scr[4], o_rdy[4];
  logic [15:0] o_blk[4];
  always #5 clk = ~clk;
  pcs_tx_sched_if #(.SEQ_W(6), .AM_CNT_W(14)) i0 ();
  pcs_tx_sched_if #(.SEQ_W(6), .AM_CNT_W(2)) i1 ();
  pcs_tx_sched_if #(.SEQ_W(6), .AM_CNT_W(5)) i2 ();
  pcs_tx_sched_if #(.SEQ_W(6), .AM_CNT_W(14)) i3 ();
  pcs_tx_sched #(.IS_10G(1'b1)) u0 (.clk(clk), .nreset(nreset), .sch(i0));
  pcs_tx_sched #(.IS_10G(1'b0), .AM_INTERVAL(4)) u1 (.clk(clk), .nreset(nreset), .sch(i1));
  pcs_tx_sched #(.IS_10G(1'b0), .AM_INTERVAL(31)) u2 (.clk(clk), .nreset(nreset), .sch(i2));
  pcs_tx_sched #(.IS_10G(1'b0)) u3 (.clk(clk), .nreset(nreset), .sch(i3));
  assign i0.en_i = en[0];
  assign i1.en_i = en[1];
  assign i2.en_i = en[2];
  assign i3.en_i = en[3];
  assign {o_seq[0], o_full[0], o_am[0], o_scr[0], o_rdy[0]} = {i0.seq_o, i0.gb_full_o, i0.am_v_o, i0.scram_v_o, i0.ready_o};
  assign {o_seq[1], o_full[1], o_am[1], o_scr[1], o_rdy[1]} = {i1.seq_o, i1.gb_full_o, i1.am_v_o, i1.scram_v_o, i1.ready_o};
  assign {o_seq[2], o_full[2], o_am[2], o_scr[2], o_rdy[2]} = {i2.seq_o, i2.gb_full_o, i2.am_v_o, i2.scram_v_o, i2.ready_o};
  assign {o_seq[3], o_full[3], o_am[3], o_scr[3], o_rdy[3]} = {i3.seq_o, i3.gb_full_o, i3.am_v_o, i3.scram_v_o, i3.ready_o};
  assign o_blk[0] = 16'(i0.blk_cnt_o);
  assign o_blk[1] = 16'(i1.blk_cnt_o);
  assign o_blk[2] = 16'(i2.blk_cnt_o);
  assign o_blk[3] = 16'(i3.blk_cnt_o);
  // k: cycles since entering RUN, j: non-full slots since entering RUN
  function automatic exp_t model_out(int i);
    exp_t e = '0;
    int p;
    if (!run_m[i]) return e;
    p = j_m[i] % (ival[i] + 1);
    e.seq = 6'(k_m[i] % 33);
    e.full = (k_m[i] % 33) == 32;
    e.am = !e.full && !ten[i] && p == 0;
    e.rdy = !e.full && !e.am;
    e.scr = e.rdy;
    e.blk = ten[i] ? 16'(j_m[i] % ival[i]) : (p == 0 ? 16'd0 : 16'(p - 1));
    return e;
  endfunction
  function automatic void model_step(int i, logic e_in);
    if (!run_m[i]) begin
      if (e_in) begin
        run_m[i] = 1'b1;
        k_m[i] = 0;
        j_m[i] = 0;
      end
    end else if (!e_in) run_m[i] = 1'b0;
    else begin
      if (k_m[i] % 33 != 32) j_m[i]++;
      k_m[i]++;
    end
  endfunction
  task automatic step(input int mode);
    @(posedge clk);
    #2;
    if (mode == 1) en = 4'hf;
    for (int i = 0; i < 3; i++)
      if (mode == 2 && $urandom_range(49) == 0) en[i] = ~en[i];
    for (int i = 0; i < 4; i++) begin
      model_step(i, en[i]);
      q[i].push_back(model_out(i));
    end
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        exp_t a, e;
        a.seq = o_seq[i];
        a.full = o_full[i];
        a.am = o_am[i];
        a.scr = o_scr[i];
        a.rdy = o_rdy[i];
        a.blk = o_blk[i];
        checks++;
        if (q[i].size() == 0) begin
          errors++;
          $display("FAIL sb_underflow dut%0d t=%0t", i, $time);
        end else begin
          e = q[i].pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL sb dut%0d t=%0t got seq=%0d full=%0b am=%0b scr=%0b rdy=%0b blk=%0d expected seq=%0d full=%0b am=%0b scr=%0b rdy=%0b blk=%0d",
                     i, $time, a.seq, a.full, a.am, a.scr, a.rdy, a.blk, e.seq, e.full, e.am, e.scr, e.rdy, e.blk);
          end
        end
      end
      if (o_am[3]) begin
        if (seen) gaps.push_back(rcnt);
        seen = 1'b1;
        rcnt = 0;
      end else if (o_rdy[3]) rcnt++;
      if (prev_full2 && o_am[2]) hit31++;
      prev_full2 = o_full[2];
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #2;
    nreset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_m[i] = 1'b0;
      k_m[i] = 0;
      j_m[i] = 0;
      q[i].push_back(model_out(i));
      model_step(i, 1'b0);
      q[i].push_back(model_out(i));
    end
    mon_en = 1'b1;
    repeat (10) step(0);
    step(1);
    repeat (99) step(0);
    repeat (34000) step(2);
    step(1);
    repeat (40) step(0);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    nreset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({o_seq[i], o_full[i], o_am[i], o_scr[i], o_rdy[i], o_blk[i]} !== '0) begin
        errors++;
        $display("FAIL async_reset dut%0d got seq=%0d full=%0b am=%0b scr=%0b rdy=%0b blk=%0d expected all 0",
                 i, o_seq[i], o_full[i], o_am[i], o_scr[i], o_rdy[i], o_blk[i]);
      end
    end
    checks++;
    if (gaps.size() != 2) begin
      errors++;
      $display("FAIL am_gap_count got %0d expected 2", gaps.size());
    end
    foreach (gaps[g]) begin
      checks++;
      if (gaps[g] != 16383) begin
        errors++;
        $display("FAIL am_gap%0d got %0d expected 16383", g, gaps[g]);
      end
    end
    checks++;
    if (hit31 == 0) begin
      errors++;
      $display("FAIL am_after_full got %0d occurrences expected >0", hit31);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
